dmem_arbiter: RTL

- Shares the single-ported 64-word data memory between the two load/store lanes of the dual-issue pipeline.
- Lane 0 is the older instruction and lane 1 the younger.
- Grants at most one memory access per cycle and preserves program order on same-word hazards; otherwise uses round-robin.
- Steers the one-cycle-late synchronous read data back to the issuing lane. Sits between the MEM stage and data_memory.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, lane ids and address helpers for the data-memory arbiter
package mem_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int WORD_LSB  = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_t;

  function automatic logic same_word(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:WORD_LSB] == b[ADDR_W-1:WORD_LSB];
  endfunction

  function automatic logic word_in_range(input logic [ADDR_W-1:0] a, input int unsigned depth);
    return 32'(a >> WORD_LSB) < depth;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with a lane-0 priority override
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       prio0,
  output logic [1:0] grant
);

  lane_t rr_ptr, rr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= LANE0;
    else       rr_ptr <= rr_ptr_nxt;
  end

  // Only contested grants move the pointer, always away from the lane just served.
  always_comb begin
    grant      = 2'b00;
    rr_ptr_nxt = rr_ptr;
    if (!reset) begin
      case (req)
        2'b01: grant = 2'b01;
        2'b10: grant = 2'b10;
        2'b11: begin
          if (prio0 || rr_ptr == LANE0) begin
            grant      = 2'b01;
            rr_ptr_nxt = LANE1;
          end else begin
            grant      = 2'b10;
            rr_ptr_nxt = LANE0;
          end
        end
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-ported data memory between two load/store lanes
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  logic [1:0]        grant;
  logic              granted;
  lane_t             win;
  logic              prio0;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_in_range;

  logic              ret_valid;
  lane_t             ret_lane;
  logic              ret_oor;
  logic [CNT_W-1:0]  cnt_q;

  // A store touching the same word as the other lane must not be reordered.
  assign prio0 = same_word(addr0, addr1) & (we0 | we1);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .prio0 (prio0),
    .grant (grant)
  );

  assign granted = |grant;
  assign win     = grant[1] ? LANE1 : LANE0;
  assign ack0    = grant[0];
  assign ack1    = grant[1];

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (grant[0]) begin
      sel_addr  = addr0;
      sel_wdata = wdata0;
      sel_we    = we0;
    end else if (grant[1]) begin
      sel_addr  = addr1;
      sel_wdata = wdata1;
      sel_we    = we1;
    end
  end

  assign sel_in_range   = word_in_range(sel_addr, DEPTH);
  assign mem_address    = sel_addr;
  assign mem_write_data = sel_wdata;
  assign mem_write      = sel_we & sel_in_range;

  // ret_oor is loaded on every grant so it also flags dropped stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_valid <= 1'b0;
      ret_lane  <= LANE0;
      ret_oor   <= 1'b0;
    end else begin
      ret_valid <= granted & ~sel_we;
      ret_oor   <= granted & ~sel_in_range;
      if (granted) ret_lane <= win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                           cnt_q <= '0;
    else if (req0 && req1 && !(&cnt_q))  cnt_q <= cnt_q + 1'b1;
  end

  assign conflict_cnt = cnt_q;

  // Reset discards a return that is still in flight.
  assign rvalid0 = ret_valid & (ret_lane == LANE0) & ~reset;
  assign rvalid1 = ret_valid & (ret_lane == LANE1) & ~reset;
  assign rdata0  = (rvalid0 && !ret_oor) ? mem_read_data : '0;
  assign rdata1  = (rvalid1 && !ret_oor) ? mem_read_data : '0;
  assign err     = ret_oor & ~reset;

endmodule
